// File: rtl/mem_pkg.sv
// Shared types for the L1 data cache: FSM states, bus transaction record, size defaults.
// Also holds the byte-enable merge helper used on write-hit updates.
package mem_pkg;
   localparam int DEF_XLEN  = 32;
   localparam int DEF_LINES = 16;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_DONE = 2'd3
   } state_t;

   typedef struct packed {
      logic                we;
      logic [DEF_XLEN-1:0] addr;
      logic [3:0]          be;
      logic [DEF_XLEN-1:0] wdata;
   } bus_txn_t;

   function automatic logic [DEF_XLEN-1:0] merge_be(input logic [DEF_XLEN-1:0] old_w,
                                                    input logic [DEF_XLEN-1:0] new_w,
                                                    input logic [3:0]          be);
      logic [DEF_XLEN-1:0] res;
      res = old_w;
      for (int b = 0; b < 4; b++) begin
         if (be[b]) res[8*b +: 8] = new_w[8*b +: 8];
      end
      return res;
   endfunction
endpackage

// File: rtl/dcache_array.sv
// Direct-mapped tag/valid/data store: combinational read, one write port, one invalidate port.
// A snoop matching the line being written in the same cycle leaves that line invalid.
module dcache_array #(
   parameter int XLEN  = 32,
   parameter int LINES = 16,
   parameter int IW    = $clog2(LINES),
   parameter int TW    = XLEN - IW - 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [IW-1:0]   i_rd_idx,
   output logic            o_rd_valid,
   output logic [TW-1:0]   o_rd_tag,
   output logic [XLEN-1:0] o_rd_data,
   input  logic            i_wr_en,
   input  logic [IW-1:0]   i_wr_idx,
   input  logic [TW-1:0]   i_wr_tag,
   input  logic [XLEN-1:0] i_wr_data,
   input  logic            i_inv_en,
   input  logic [IW-1:0]   i_inv_idx,
   input  logic [TW-1:0]   i_inv_tag
);
   logic [LINES-1:0] r_valid;
   logic [TW-1:0]    r_tag  [LINES];
   logic [XLEN-1:0]  r_data [LINES];
   logic             w_inv_hits_wr;

   assign o_rd_valid = r_valid[i_rd_idx];
   assign o_rd_tag   = r_tag[i_rd_idx];
   assign o_rd_data  = r_data[i_rd_idx];

   assign w_inv_hits_wr = i_inv_en && (i_inv_idx == i_wr_idx) && (i_inv_tag == i_wr_tag);

   always_ff @(posedge clk) begin
      if (i_wr_en) begin
         r_tag[i_wr_idx]  <= i_wr_tag;
         r_data[i_wr_idx] <= i_wr_data;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < LINES; gi++) begin : g_valid
         // Write owns the valid bit of its line; snoop only clears lines not being rewritten.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_valid[gi] <= 1'b0;
            end else if (i_wr_en && (i_wr_idx == IW'(gi))) begin
               r_valid[gi] <= !w_inv_hits_wr;
            end else if (i_inv_en && (i_inv_idx == IW'(gi)) && (r_tag[gi] == i_inv_tag)) begin
               r_valid[gi] <= 1'b0;
            end
         end
      end
   endgenerate
endmodule

// File: rtl/l1_dcache.sv
// Write-through, no-write-allocate direct-mapped L1 data cache with one-word lines.
// Misses and all stores go to a shared bus through an IDLE/REQ/WAIT/DONE handshake.
module l1_dcache
   import mem_pkg::*;
#(
   parameter int XLEN  = DEF_XLEN,
   parameter int LINES = DEF_LINES
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            dmem_memRead,
   input  logic            dmem_memWrite,
   input  logic [3:0]      dmem_be,
   input  logic [XLEN-1:0] dmem_addr,
   input  logic [XLEN-1:0] dmem_wdata,
   output logic [XLEN-1:0] dmem_rdata,
   output logic            dmem_stall,
   output logic            bus_req,
   input  logic            bus_gnt,
   output logic            bus_we,
   output logic [XLEN-1:0] bus_addr,
   output logic [3:0]      bus_be,
   output logic [XLEN-1:0] bus_wdata,
   input  logic            bus_ack,
   input  logic [XLEN-1:0] bus_rdata,
   input  logic            snoop_valid,
   input  logic [XLEN-1:0] snoop_addr
);
   localparam int IW = $clog2(LINES);
   localparam int TW = XLEN - IW - 2;

   state_t          r_state, w_state_next;
   bus_txn_t        r_txn;
   logic [XLEN-1:0] r_resp;
   logic [XLEN-1:0] w_lookup_addr;
   logic            w_rd_valid;
   logic [TW-1:0]   w_rd_tag;
   logic [XLEN-1:0] w_rd_data;
   logic            w_hit, w_start, w_ack, w_fill, w_wmerge;
   logic [XLEN-1:0] w_wr_data;
   logic            w_unused_snoop;

   // In IDLE the array is probed with the live core address; afterwards with the held one.
   assign w_lookup_addr = (r_state == S_IDLE) ? dmem_addr : r_txn.addr;
   assign w_hit     = w_rd_valid && (w_rd_tag == w_lookup_addr[XLEN-1:IW+2]);
   assign w_start   = (r_state == S_IDLE) && ((dmem_memRead && !w_hit) || dmem_memWrite);
   assign w_ack     = (r_state == S_WAIT) && bus_ack;
   assign w_fill    = w_ack && !r_txn.we;
   assign w_wmerge  = w_ack && r_txn.we && w_hit;
   assign w_wr_data = w_fill ? bus_rdata : merge_be(w_rd_data, r_txn.wdata, r_txn.be);
   assign w_unused_snoop = ^snoop_addr[1:0];

   dcache_array #(.XLEN(XLEN), .LINES(LINES)) u_array (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_rd_idx   (w_lookup_addr[IW+1:2]),
      .o_rd_valid (w_rd_valid),
      .o_rd_tag   (w_rd_tag),
      .o_rd_data  (w_rd_data),
      .i_wr_en    (w_fill || w_wmerge),
      .i_wr_idx   (r_txn.addr[IW+1:2]),
      .i_wr_tag   (r_txn.addr[XLEN-1:IW+2]),
      .i_wr_data  (w_wr_data),
      .i_inv_en   (snoop_valid),
      .i_inv_idx  (snoop_addr[IW+1:2]),
      .i_inv_tag  (snoop_addr[XLEN-1:IW+2])
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (w_start) w_state_next = S_REQ;
         S_REQ:   if (bus_gnt) w_state_next = S_WAIT;
         S_WAIT:  if (bus_ack) w_state_next = S_DONE;
         default: w_state_next = S_IDLE;
      endcase
   end

   always_comb begin
      dmem_stall = 1'b0;
      bus_req    = 1'b0;
      dmem_rdata = r_resp;
      case (r_state)
         S_IDLE: begin
            dmem_stall = w_start;
            if (dmem_memRead && w_hit) dmem_rdata = w_rd_data;
         end
         S_REQ: begin
            dmem_stall = 1'b1;
            bus_req    = 1'b1;
         end
         S_WAIT:  dmem_stall = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_txn  <= '0;
         r_resp <= '0;
      end else begin
         if (w_start) begin
            r_txn.we    <= dmem_memWrite;
            r_txn.addr  <= dmem_addr;
            r_txn.be    <= dmem_memWrite ? dmem_be : 4'b1111;
            r_txn.wdata <= dmem_wdata;
         end
         if (w_fill) r_resp <= bus_rdata;
      end
   end

   assign bus_we    = r_txn.we;
   assign bus_addr  = r_txn.addr;
   assign bus_be    = r_txn.be;
   assign bus_wdata = r_txn.wdata;
endmodule

// File: tb/tb_l1_dcache.sv
// Directed bench for l1_dcache: miss/hit latency, write-through merge, no-allocate,
// snoop invalidation (alone, with fill, with hit) and reset during a transaction.
module tb_l1_dcache;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        dmem_memRead, dmem_memWrite;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic        dmem_stall;
   logic        bus_req, bus_gnt, bus_we, bus_ack;
   logic [31:0] bus_addr, bus_wdata, bus_rdata;
   logic [3:0]  bus_be;
   logic        snoop_valid;
   logic [31:0] snoop_addr;

   int total = 0;
   int bad   = 0;

   int          st;
   logic [31:0] rs, s_addr, s_wdata;
   logic        s_we, tmo;
   logic [3:0]  s_be;

   always #5 clk = ~clk;

   l1_dcache dut (
      .clk(clk), .rst_n(rst_n),
      .dmem_memRead(dmem_memRead), .dmem_memWrite(dmem_memWrite), .dmem_be(dmem_be),
      .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
      .dmem_stall(dmem_stall),
      .bus_req(bus_req), .bus_gnt(bus_gnt), .bus_we(bus_we), .bus_addr(bus_addr),
      .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
      .snoop_valid(snoop_valid), .snoop_addr(snoop_addr)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
      $display("check %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic start_rd(input logic [31:0] a);
      dmem_memRead = 1'b1; dmem_memWrite = 1'b0; dmem_addr = a;
   endtask

   task automatic start_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
      dmem_memRead = 1'b0; dmem_memWrite = 1'b1; dmem_addr = a; dmem_wdata = d; dmem_be = be;
   endtask

   task automatic drop_req();
      dmem_memRead = 1'b0; dmem_memWrite = 1'b0;
   endtask

   // Called at a negedge with the request already driven; returns in the DONE cycle.
   task automatic run_txn(input int gnt_at, input int ack_at, input logic [31:0] rd,
                          input logic snp, input logic [31:0] snp_a,
                          output int stalls, output logic [31:0] resp,
                          output logic we, output logic [31:0] addr,
                          output logic [3:0] be, output logic [31:0] wdata,
                          output logic timeout);
      int req_n, wait_n;
      stalls = 0; req_n = 0; wait_n = 0; timeout = 1'b1;
      resp = '0; we = 1'b0; addr = '0; be = '0; wdata = '0;
      for (int guard = 0; guard < 50; guard++) begin
         #1;
         if (!dmem_stall) begin
            resp = dmem_rdata; timeout = 1'b0;
            break;
         end
         stalls++;
         if (bus_req) begin
            req_n++;
            we = bus_we; addr = bus_addr; be = bus_be; wdata = bus_wdata;
            bus_gnt = (req_n == gnt_at);
         end else if (req_n > 0) begin
            wait_n++;
            if (wait_n == ack_at) begin
               bus_ack = 1'b1; bus_rdata = rd;
               if (snp) begin snoop_valid = 1'b1; snoop_addr = snp_a; end
            end
         end
         @(negedge clk);
         bus_gnt = 1'b0; bus_ack = 1'b0; snoop_valid = 1'b0;
      end
   endtask

   initial begin
      rst_n = 1'b0; dmem_memRead = 1'b0; dmem_memWrite = 1'b0; dmem_be = 4'h0;
      dmem_addr = '0; dmem_wdata = '0; bus_gnt = 1'b0; bus_ack = 1'b0; bus_rdata = '0;
      snoop_valid = 1'b0; snoop_addr = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rst_stall", {31'd0, dmem_stall}, 32'd0);
      check("rst_rdata", dmem_rdata, 32'h0);
      check("rst_bus_req", {31'd0, bus_req}, 32'd0);
      check("rst_bus_we", {31'd0, bus_we}, 32'd0);

      // Cold read miss: grant on 2nd REQ cycle, ack on 3rd WAIT cycle -> 6 stall cycles.
      @(negedge clk);
      start_rd(32'h40);
      run_txn(2, 3, 32'hDEAD_BEEF, 1'b0, '0, st, rs, s_we, s_addr, s_be, s_wdata, tmo);
      check("miss_timeout", {31'd0, tmo}, 32'd0);
      check("miss_stalls", st, 32'd6);
      check("miss_done_rdata", rs, 32'hDEAD_BEEF);
      check("miss_bus_we", {31'd0, s_we}, 32'd0);
      check("miss_bus_addr", s_addr, 32'h40);
      check("miss_bus_be", {28'd0, s_be}, 32'hF);
      drop_req();
      @(negedge clk);
      start_rd(32'h40);
      #1;
      check("rehit_stall", {31'd0, dmem_stall}, 32'd0);
      check("rehit_rdata", dmem_rdata, 32'hDEAD_BEEF);
      check("rehit_bus_req", {31'd0, bus_req}, 32'd0);
      drop_req();

      // Write hit: write-through with byte merge.
      @(negedge clk);
      start_wr(32'h40, 32'h1234_5678, 4'b0011);
      run_txn(1, 1, 32'h0, 1'b0, '0, st, rs, s_we, s_addr, s_be, s_wdata, tmo);
      check("wr_stalls", st, 32'd3);
      check("wr_bus_we", {31'd0, s_we}, 32'd1);
      check("wr_bus_be", {28'd0, s_be}, 32'h3);
      check("wr_bus_wdata", s_wdata, 32'h1234_5678);
      drop_req();
      @(negedge clk);
      start_rd(32'h40);
      #1;
      check("merged_stall", {31'd0, dmem_stall}, 32'd0);
      check("merged_rdata", dmem_rdata, 32'hDEAD_5678);
      drop_req();

      // Snoop to same index, other tag: no effect. Then matching snoop: invalidates.
      @(negedge clk);
      snoop_valid = 1'b1; snoop_addr = 32'h440;
      @(negedge clk);
      snoop_valid = 1'b0;
      start_rd(32'h40);
      #1;
      check("snoop_other_stall", {31'd0, dmem_stall}, 32'd0);
      drop_req();
      @(negedge clk);
      snoop_valid = 1'b1; snoop_addr = 32'h40;
      @(negedge clk);
      snoop_valid = 1'b0;
      start_rd(32'h40);
      run_txn(1, 1, 32'hABCD_0001, 1'b0, '0, st, rs, s_we, s_addr, s_be, s_wdata, tmo);
      check("snoop_miss_stalls", st, 32'd3);
      check("snoop_refill_rdata", rs, 32'hABCD_0001);
      drop_req();

      // Snoop coincident with fill: fill data returned, line left invalid.
      @(negedge clk);
      snoop_valid = 1'b1; snoop_addr = 32'h40;
      @(negedge clk);
      snoop_valid = 1'b0;
      start_rd(32'h40);
      run_txn(1, 2, 32'h55AA_55AA, 1'b1, 32'h40, st, rs, s_we, s_addr, s_be, s_wdata, tmo);
      check("fillsnoop_stalls", st, 32'd4);
      check("fillsnoop_rdata", rs, 32'h55AA_55AA);
      drop_req();
      @(negedge clk);
      start_rd(32'h40);
      run_txn(1, 1, 32'h0BAD_F00D, 1'b0, '0, st, rs, s_we, s_addr, s_be, s_wdata, tmo);
      check("fillsnoop_after_stalls", st, 32'd3);
      drop_req();

      // Store to uncached 0x80: bus write, no allocation.
      @(negedge clk);
      start_wr(32'h80, 32'hCAFE_F00D, 4'b1111);
      run_txn(1, 1, 32'h0, 1'b0, '0, st, rs, s_we, s_addr, s_be, s_wdata, tmo);
      check("noalloc_bus_addr", s_addr, 32'h80);
      check("noalloc_bus_we", {31'd0, s_we}, 32'd1);
      drop_req();
      @(negedge clk);
      start_rd(32'h80);
      run_txn(1, 2, 32'h1111_2222, 1'b0, '0, st, rs, s_we, s_addr, s_be, s_wdata, tmo);
      check("noalloc_read_stalls", st, 32'd4);
      check("noalloc_read_rdata", rs, 32'h1111_2222);
      drop_req();

      // Reset during WAIT aborts and clears all lines.
      @(negedge clk);
      start_rd(32'h48);
      #1;
      check("rstwait_idle_stall", {31'd0, dmem_stall}, 32'd1);
      @(negedge clk);
      #1;
      check("rstwait_req", {31'd0, bus_req}, 32'd1);
      bus_gnt = 1'b1;
      @(negedge clk);
      bus_gnt = 1'b0;
      #1;
      check("rstwait_wait_req", {31'd0, bus_req}, 32'd0);
      drop_req();
      rst_n = 1'b0;
      #1;
      check("rstwait_bus_req", {31'd0, bus_req}, 32'd0);
      check("rstwait_stall", {31'd0, dmem_stall}, 32'd0);
      check("rstwait_rdata", dmem_rdata, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      start_rd(32'h80);
      run_txn(1, 1, 32'h7777_8888, 1'b0, '0, st, rs, s_we, s_addr, s_be, s_wdata, tmo);
      check("rstwait_invalid_stalls", st, 32'd3);
      drop_req();

      // Snoop coincident with an IDLE hit: hit data returned, then miss.
      @(negedge clk);
      start_rd(32'h80);
      snoop_valid = 1'b1; snoop_addr = 32'h80;
      #1;
      check("hitsnoop_stall", {31'd0, dmem_stall}, 32'd0);
      check("hitsnoop_rdata", dmem_rdata, 32'h7777_8888);
      @(negedge clk);
      snoop_valid = 1'b0;
      run_txn(1, 1, 32'h9999_0000, 1'b0, '0, st, rs, s_we, s_addr, s_be, s_wdata, tmo);
      check("hitsnoop_after_stalls", st, 32'd3);
      check("hitsnoop_after_rdata", rs, 32'h9999_0000);
      drop_req();

      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/l1_dcache.md
L1_DCACHE -- requirements
Module: l1_dcache

Interface
REQ-001 Parameter XLEN, default 32, data/address width.
REQ-002 Parameter LINES, default 16, number of direct-mapped one-word lines (power of two).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 dmem_memRead  in  1  core load request, MEM stage.
REQ-006 dmem_memWrite  in  1  core store request; never asserted together with dmem_memRead.
REQ-007 dmem_be  in  4  store byte enables.
REQ-008 dmem_addr  in  XLEN  word-aligned byte address.
REQ-009 dmem_wdata  in  XLEN  store data.
REQ-010 dmem_rdata  out  XLEN  load data.
REQ-011 dmem_stall  out  1  core holds its request while high.
REQ-012 bus_req  out  1  shared-bus request.
REQ-013 bus_gnt  in  1  arbiter grant.
REQ-014 bus_we  out  1  1 = write, 0 = read.
REQ-015 bus_addr  out  XLEN; bus_be  out  4; bus_wdata  out  XLEN  transaction fields.
REQ-016 bus_ack  in  1  transaction complete; bus_rdata  in  XLEN  read data, valid with ack.
REQ-017 snoop_valid  in  1; snoop_addr  in  XLEN  store observed from another core.

Function
REQ-018 Address split: index = addr[log2(LINES)+1:2]; tag = addr[XLEN-1:log2(LINES)+2].
REQ-019 FSM states: IDLE, REQ, WAIT, DONE.
REQ-020 IDLE, read hit (valid and tag match): dmem_rdata = line data combinationally, dmem_stall=0, state stays IDLE.
REQ-021 IDLE, read miss or any write: dmem_stall=1 same cycle; next state REQ.
REQ-022 REQ: bus_req=1 with bus_we/bus_addr/bus_be/bus_wdata held stable; on bus_gnt=1, next state WAIT.
REQ-023 WAIT: bus_req=0, bus fields held; bus_ack ignored in REQ; on bus_ack=1 in WAIT, next state DONE.
REQ-024 Read completion: on ack, line[index] <- {valid=1, tag, bus_rdata}; bus_rdata also captured in a response register.
REQ-025 Write policy: write-through, no-write-allocate; on ack, a valid tag-matching line is merged per bus_be; a miss leaves the array untouched.
REQ-026 DONE: dmem_stall=0, dmem_rdata = response register, no new transaction started; next state IDLE.
REQ-027 dmem_stall = 1 in REQ and WAIT, and in IDLE per REQ-021; 0 otherwise.
REQ-028 Snoop: any cycle with snoop_valid=1, a valid line whose index and tag match snoop_addr is invalidated, in every FSM state.
REQ-029 Snoop and fill hitting the same line in one cycle: the line ends invalid; the fill data is still returned in DONE.
REQ-030 Snoop and IDLE read hitting the same line in one cycle: the hit data is returned; invalidation takes effect at the edge.
REQ-031 Latency: read hit 0 extra cycles; miss or write = 1 (REQ entry) + grant wait + ack wait + 1 (DONE).
REQ-032 dmem_be is ignored for reads; bus_be = 4'b1111 for reads.

Reset
REQ-033 rst_n low: state=IDLE, all valid bits 0, response register 0, bus_req=0, bus_we=0.
REQ-034 Reset mid-transaction aborts it with no array update; bus_req drops asynchronously.
REQ-035 After reset, dmem_stall=0 and dmem_rdata=0 while no request is present.

Structure
REQ-036 A shared package mem_pkg holds the FSM state enum, the bus-transaction struct (we, addr, be, wdata), and the LINES/XLEN defaults.
REQ-037 The tag/valid/data storage lives in a sub-module dcache_array: one read port, one write port, and a separate invalidate port.

Verification
REQ-038 After reset, read 0x0000_0040 with gnt after 2 cycles and ack 3 cycles later returning 0xDEAD_BEEF -> stall high 6 cycles, DONE rdata 0xDEAD_BEEF, immediate re-read hits with stall 0.
REQ-039 Write 0x1234_5678 with be=4'b0011 to cached 0x40 holding 0xDEAD_BEEF -> bus write issued, line becomes 0xDEAD_5678 after ack.
REQ-040 Write to uncached 0x80 -> bus write issued, later read of 0x80 misses (no allocate).
REQ-041 snoop 0x40 while line 0x40 valid -> next read of 0x40 misses and goes to the bus.
REQ-042 snoop 0x40 in the same cycle as the ack filling 0x40 -> DONE returns fill data, line invalid afterwards.
REQ-043 rst_n low during WAIT -> bus_req 0, state IDLE, all lines invalid, stall 0.
